// File: rtl/rand_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rand_pkg
//  Brief    : Shared constants and FSM encoding for the bounded random source.
//  Revision : 1.0  initial release
// ============================================================================
package rand_pkg;

  // Width of the LCG state word; results are taken from its upper bits.
  localparam int LCG_STATE_W = 31;

  // ISO C LCG constants (1103515245, 12345).
  localparam logic [31:0] LCG_A_DEFAULT = 32'h41C64E6D;
  localparam logic [31:0] LCG_C_DEFAULT = 32'h00003039;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } rand_fsm_t;

endpackage : rand_pkg
`default_nettype wire

// File: rtl/rand_lcg_core.sv
`default_nettype none
// ============================================================================
//  Module   : rand_lcg_core
//  Brief    : 31-bit linear congruential generator with seed load and step.
//             Owns all LCG arithmetic so other blocks can reuse it directly.
//  Revision : 1.0  initial release
// ============================================================================
module rand_lcg_core
  import rand_pkg::*;
#(
  parameter logic [LCG_STATE_W-1:0] SEED  = 31'd1,
  parameter logic [31:0]            LCG_A = LCG_A_DEFAULT,
  parameter logic [31:0]            LCG_C = LCG_C_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [LCG_STATE_W-1:0] seed_i,
  input  logic                   step_i,
  output logic [LCG_STATE_W-1:0] next_o,
  output logic [LCG_STATE_W-1:0] state_o
);

  // Only the low 31 bits of the multiplier and increment affect a mod-2^31 result.
  localparam logic [LCG_STATE_W-1:0] c_A_LO = LCG_A[LCG_STATE_W-1:0];
  localparam logic [LCG_STATE_W-1:0] c_C_LO = LCG_C[LCG_STATE_W-1:0];

  logic [LCG_STATE_W-1:0] state_q;
  logic [LCG_STATE_W-1:0] state_d;
  logic [LCG_STATE_W-1:0] w_next;

  // Next LCG value, truncated to the state width.
  assign w_next = (state_q * c_A_LO) + c_C_LO;

  // Load has priority over step; otherwise the state holds.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = w_next;
    end
  end

  // State register, reset to the seed parameter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign next_o  = w_next;
  assign state_o = state_q;

endmodule : rand_lcg_core
`default_nettype wire

// File: rtl/rand_range_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rand_range_gen
//  Brief    : Bounded random draw in [0, span) from an LCG, scaled with a
//             sequential shift-add multiply and a req/valid handshake.
//  Revision : 1.0  initial release
// ============================================================================
module rand_range_gen
  import rand_pkg::*;
#(
  parameter int                     OUT_W = 16,
  parameter logic [LCG_STATE_W-1:0] SEED  = 31'd1,
  parameter logic [31:0]            LCG_A = LCG_A_DEFAULT,
  parameter logic [31:0]            LCG_C = LCG_C_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   seed_load_i,
  input  logic [LCG_STATE_W-1:0] seed_in_i,
  input  logic                   req_i,
  input  logic [OUT_W-1:0]       span_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [OUT_W-1:0]       rand_out_o,
  output logic [LCG_STATE_W-1:0] raw_state_o
);

  localparam int                 c_CNT_W = $clog2(OUT_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(OUT_W - 1);

  rand_fsm_t                fsm_q, fsm_d;
  logic [2*OUT_W-1:0]       acc_q, acc_d;
  logic [c_CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0]         r_q, r_d;
  logic [OUT_W-1:0]         span_q, span_d;
  logic [OUT_W-1:0]         rand_out_q, rand_out_d;

  logic                     w_lcg_step;
  logic [LCG_STATE_W-1:0]   w_lcg_next;
  logic [LCG_STATE_W-1:0]   w_lcg_state;
  logic                     w_next_unused;
  logic [2*OUT_W-1:0]       w_partial;
  logic                     w_span_bit;
  logic [2*OUT_W-1:0]       w_acc_sum;

  rand_lcg_core #(
    .SEED  (SEED),
    .LCG_A (LCG_A),
    .LCG_C (LCG_C)
  ) u_lcg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seed_load_i),
    .seed_i  (seed_in_i),
    .step_i  (w_lcg_step),
    .next_o  (w_lcg_next),
    .state_o (w_lcg_state)
  );

  // The draw uses only the upper bits of the next state; the rest are dropped.
  assign w_next_unused = ^w_lcg_next;

  // One shift-add multiply step: add r<<cnt when bit cnt of span is set.
  assign w_partial  = {{OUT_W{1'b0}}, r_q} << cnt_q;
  assign w_span_bit = |(span_q & (OUT_W'(1) << cnt_q));
  assign w_acc_sum  = w_span_bit ? (acc_q + w_partial) : acc_q;

  // Next-state and datapath control; seed_load aborts any draw in progress.
  always_comb begin
    fsm_d      = fsm_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    span_d     = span_q;
    rand_out_d = rand_out_q;
    w_lcg_step = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (seed_load_i) begin
          fsm_d = IDLE;
        end else if (req_i) begin
          w_lcg_step = 1'b1;
          r_d        = w_lcg_next[LCG_STATE_W-1 -: OUT_W];
          span_d     = span_i;
          acc_d      = '0;
          cnt_d      = '0;
          fsm_d      = MUL;
        end else if (en_i) begin
          w_lcg_step = 1'b1;
        end
      end
      MUL: begin
        if (seed_load_i) begin
          fsm_d = IDLE;
        end else begin
          acc_d = w_acc_sum;
          cnt_d = cnt_q + c_CNT_W'(1);
          if (cnt_q == c_LAST) begin
            fsm_d      = DONE;
            rand_out_d = (span_q == '0) ? r_q : w_acc_sum[2*OUT_W-1:OUT_W];
          end
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      r_q        <= '0;
      span_q     <= '0;
      rand_out_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      span_q     <= span_d;
      rand_out_q <= rand_out_d;
    end
  end

  assign busy_o      = (fsm_q == MUL) || (fsm_q == DONE);
  assign valid_o     = (fsm_q == DONE);
  assign rand_out_o  = rand_out_q;
  assign raw_state_o = w_lcg_state;

endmodule : rand_range_gen
`default_nettype wire

// File: tb/tb_rand_range_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rand_range_gen
//  Brief    : Self-checking bench for rand_range_gen against an arithmetic
//             model of the LCG and of the bounded-draw scaling.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rand_range_gen;

  localparam int OUT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              seed_load;
  logic [30:0]       seed_in;
  logic              req;
  logic [OUT_W-1:0]  span;
  logic              busy_o;
  logic              valid_o;
  logic [OUT_W-1:0]  rand_out_o;
  logic [30:0]       raw_state_o;

  int                checks = 0;
  int                errors = 0;
  logic [30:0]       m_state;

  rand_range_gen #(.OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .seed_load_i (seed_load),
    .seed_in_i   (seed_in),
    .req_i       (req),
    .span_i      (span),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .rand_out_o  (rand_out_o),
    .raw_state_o (raw_state_o)
  );

  always #5 clk = ~clk;

  // Reference LCG: (s*1103515245 + 12345) mod 2^31 in plain integer arithmetic.
  function automatic logic [30:0] model_step(input logic [30:0] s);
    longint unsigned t;
    t = 64'(s);
    t = (t * 64'd1103515245 + 64'd12345) % 64'd2147483648;
    return t[30:0];
  endfunction

  // Reference draw: r = state / 2^15 (top 16 bits); scaled as floor(r*span/2^16).
  function automatic logic [OUT_W-1:0] model_draw(input logic [30:0] s, input logic [OUT_W-1:0] sp);
    longint unsigned r;
    longint unsigned p;
    r = 64'(s) / 64'd32768;
    if (sp == 0) return r[OUT_W-1:0];
    p = (r * 64'(sp)) / 64'd65536;
    return p[OUT_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0; span = '0;
    tick();
    tick();
    rst = 1'b0;
    m_state = 31'd1;
  endtask

  // Issue one request from IDLE and wait (bounded) for its valid pulse.
  task automatic draw(input logic [OUT_W-1:0] sp, output logic [OUT_W-1:0] res, output int lat);
    span = sp;
    req  = 1'b1;
    tick();
    req  = 1'b0;
    m_state = model_step(m_state);
    lat = 0;
    while (valid_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    res = rand_out_o;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL draw_timeout: valid=%b after %0d clocks, required 1", valid_o, lat);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 4;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    if (rand_out_o !== 16'h0) begin errors++; $display("FAIL reset_rand_out: got %h want 0000", rand_out_o); end
    if (raw_state_o !== 31'd1) begin errors++; $display("FAIL reset_state: got %h want 1", raw_state_o); end
  endtask

  task automatic test_span0();
    logic [OUT_W-1:0] res;
    int lat;
    reset_dut();
    draw(16'd0, res, lat);
    checks += 6;
    if (lat != OUT_W) begin errors++; $display("FAIL span0_latency: got %0d want %0d", lat, OUT_W); end
    if (res !== 16'h838C) begin errors++; $display("FAIL span0_value: got %h want 838c", res); end
    if (res !== model_draw(m_state, 16'd0)) begin errors++; $display("FAIL span0_model: got %h want %h", res, model_draw(m_state, 16'd0)); end
    if (raw_state_o !== 31'h41C67EA6) begin errors++; $display("FAIL span0_state: got %h want 41c67ea6", raw_state_o); end
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL span0_pulse: valid=%b busy=%b want 0 0", valid_o, busy_o); end
    if (rand_out_o !== 16'h838C) begin errors++; $display("FAIL span0_hold: got %h want 838c", rand_out_o); end
  endtask

  task automatic test_span10();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] exp_v;
    int lat;
    bit seen [10];
    reset_dut();
    for (int i = 0; i < 10; i++) seen[i] = 1'b0;
    draw(16'd10, res, lat);
    checks++;
    if (res !== 16'd5) begin errors++; $display("FAIL span10_first: got %0d want 5", res); end
    for (int i = 0; i < 1000; i++) begin
      draw(16'd10, res, lat);
      exp_v = model_draw(m_state, 16'd10);
      checks += 2;
      if (res !== exp_v) begin errors++; $display("FAIL span10_model[%0d]: got %0d want %0d", i, res, exp_v); end
      if (res >= 16'd10) begin errors++; $display("FAIL span10_bound[%0d]: got %0d want <10", i, res); end
      else seen[res] = 1'b1;
    end
    for (int v = 0; v < 10; v++) begin
      checks++;
      if (!seen[v]) begin errors++; $display("FAIL span10_cover: value %0d seen=0 want 1", v); end
    end
  endtask

  task automatic test_random_spans();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] sp;
    logic [OUT_W-1:0] exp_v;
    int lat;
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: sp = 16'd1;
        1: sp = 16'd0;
        2: sp = 16'hFFFF;
        default: sp = OUT_W'($urandom);
      endcase
      draw(sp, res, lat);
      exp_v = model_draw(m_state, sp);
      checks += 2;
      if (res !== exp_v) begin errors++; $display("FAIL rand_span[%0d]: span=%h got %h want %h", i, sp, res, exp_v); end
      if (sp != 0 && res >= sp) begin errors++; $display("FAIL rand_bound[%0d]: span=%h got %h want below span", i, sp, res); end
      if (sp == 1 && res != 0) begin errors++; $display("FAIL span1_zero[%0d]: got %h want 0", i, res); end
    end
  endtask

  task automatic test_seed_reload();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] sp;
    int lat;
    en = 1'b1;
    repeat ($urandom_range(3, 40)) tick();
    en = 1'b0;
    seed_load = 1'b1; seed_in = 31'd1; req = 1'b1; span = 16'd0;
    tick();
    seed_load = 1'b0; req = 1'b0;
    m_state = 31'd1;
    checks += 2;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL seed_vs_req: busy=%b want 0", busy_o); end
    if (raw_state_o !== 31'd1) begin errors++; $display("FAIL seed_load_state: got %h want 1", raw_state_o); end
    draw(16'd0, res, lat);
    checks += 2;
    if (res !== 16'h838C) begin errors++; $display("FAIL seed_repro: got %h want 838c", res); end
    if (raw_state_o !== 31'h41C67EA6) begin errors++; $display("FAIL seed_repro_state: got %h want 41c67ea6", raw_state_o); end
    seed_load = 1'b1; seed_in = 31'd0;
    tick();
    seed_load = 1'b0;
    m_state = 31'd0;
    sp = OUT_W'($urandom);
    draw(sp, res, lat);
    checks += 2;
    if (res !== model_draw(m_state, sp)) begin errors++; $display("FAIL seed_zero_draw: got %h want %h", res, model_draw(m_state, sp)); end
    if (raw_state_o !== 31'd12345) begin errors++; $display("FAIL seed_zero_state: got %h want 3039", raw_state_o); end
  endtask

  task automatic test_abort();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] prev;
    logic [30:0] sd;
    int lat;
    int nvalid;
    reset_dut();
    draw(16'd0, prev, lat);
    span = OUT_W'($urandom);
    req  = 1'b1;
    tick();
    req  = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy_o); end
    sd = 31'($urandom);
    seed_load = 1'b1; seed_in = sd;
    tick();
    seed_load = 1'b0;
    checks += 4;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", valid_o); end
    if (raw_state_o !== sd) begin errors++; $display("FAIL abort_state: got %h want %h", raw_state_o, sd); end
    if (rand_out_o !== prev) begin errors++; $display("FAIL abort_hold: got %h want %h", rand_out_o, prev); end
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_o === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", nvalid); end
    m_state = sd;
    draw(16'd0, res, lat);
    checks++;
    if (res !== model_draw(m_state, 16'd0)) begin errors++; $display("FAIL abort_next_draw: got %h want %h", res, model_draw(m_state, 16'd0)); end
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] sp;
    logic exp_valid;
    int pulses;
    reset_dut();
    sp = OUT_W'($urandom_range(2, 65535));
    span = sp;
    req  = 1'b1;
    tick();
    m_state = model_step(m_state);
    pulses = 0;
    for (int cyc = 1; cyc < 90; cyc++) begin
      tick();
      exp_valid = ((cyc % (OUT_W + 2)) == OUT_W);
      checks++;
      if (valid_o !== exp_valid) begin errors++; $display("FAIL b2b_valid[cyc %0d]: got %b want %b", cyc, valid_o, exp_valid); end
      if (valid_o === 1'b1) begin
        pulses++;
        checks++;
        if (rand_out_o !== model_draw(m_state, sp)) begin
          errors++; $display("FAIL b2b_value[%0d]: got %h want %h", pulses, rand_out_o, model_draw(m_state, sp));
        end
        m_state = model_step(m_state);
      end
    end
    req = 1'b0;
    tick();
    checks += 2;
    if (pulses != 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", pulses); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_drop_req: busy=%b want 0", busy_o); end
  endtask

  task automatic test_free_run();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] sp;
    int lat;
    reset_dut();
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    repeat (3) m_state = model_step(m_state);
    sp = OUT_W'($urandom);
    draw(sp, res, lat);
    checks += 2;
    if (res !== model_draw(m_state, sp)) begin errors++; $display("FAIL freerun_draw: got %h want %h", res, model_draw(m_state, sp)); end
    if (raw_state_o !== m_state) begin errors++; $display("FAIL freerun_state: got %h want %h", raw_state_o, m_state); end
    span = OUT_W'($urandom);
    req  = 1'b1;
    tick();
    req  = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL midmul_rst_busy: got %b want 0", busy_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midmul_rst_valid: got %b want 0", valid_o); end
    if (rand_out_o !== 16'h0) begin errors++; $display("FAIL midmul_rst_out: got %h want 0000", rand_out_o); end
    if (raw_state_o !== 31'd1) begin errors++; $display("FAIL midmul_rst_state: got %h want 1", raw_state_o); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_span0();
    test_span10();
    test_random_spans();
    test_seed_reload();
    test_abort();
    test_back_to_back();
    test_free_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rand_range_gen
`default_nettype wire
